// File: rtl/timer_a_ctrl.sv
// timer_a_ctrl
// Timer_A core controller for one Timer_A instance. Owns TAxCTL, TAxR,
// TAxEX0 and TAxIV, builds the prescaled timer tick, runs the 16-bit
// counter (stop/up/continuous/up-down) and arbitrates the interrupt
// vector for the CCM array.
//
// Ports:
//   MCLK, reset          clock and asynchronous active-low reset
//   MAB, MDBwrite, MW,   memory bus address, write data, write strobe,
//   BW, MRD              byte-write qualifier, read strobe
//   *_en                 one-MCLK clock-source strobes (TACLK/ACLK/SMCLK/INCLK)
//   TAxCCR0, EQU0        CCR0 value and equality from CCM0
//   CCIFG, CCIE          per-channel flags and enables from the CCMs
//   TAxRcurrent          counter value shared with all CCMs
//   TimerClock           one-MCLK pulse in the cycle after each count step
//   CCIFGclr             one-MCLK flag-clear pulses back to the CCMs
//   IRQ0, IRQ1           CCR0 interrupt and combined TAxIV interrupt
//   MDBread              read data, zero when no register is being read
module timer_a_ctrl #(
    parameter logic [15:0] CTLx = 16'h0340,
    parameter logic [15:0] Rx   = 16'h0350,
    parameter logic [15:0] EXx  = 16'h0360,
    parameter logic [15:0] IVx  = 16'h036E,
    parameter int          NCCM = 3
) (
    input  logic            MCLK,
    input  logic            reset,
    input  logic [15:0]     MAB,
    input  logic [15:0]     MDBwrite,
    input  logic            MW,
    input  logic            BW,
    input  logic            MRD,
    input  logic            TACLK_en,
    input  logic            ACLK_en,
    input  logic            SMCLK_en,
    input  logic            INCLK_en,
    input  logic [15:0]     TAxCCR0,
    input  logic            EQU0,
    input  logic [NCCM-1:0] CCIFG,
    input  logic [NCCM-1:0] CCIE,
    output logic [15:0]     TAxRcurrent,
    output logic            TimerClock,
    output logic [NCCM-1:0] CCIFGclr,
    output logic            IRQ0,
    output logic            IRQ1,
    output logic [15:0]     MDBread
);

    typedef enum logic [1:0] {
        MC_STOP = 2'b00,
        MC_UP   = 2'b01,
        MC_CONT = 2'b10,
        MC_UPDN = 2'b11
    } mcMode_e;

    mcMode_e         mc_q, mc_d;
    logic [1:0]      tassel_q, tassel_d;
    logic [1:0]      id_q, id_d;
    logic            taie_q, taie_d;
    logic            taifg_q, taifg_d;
    logic [2:0]      taidex_q, taidex_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic [2:0]      idCnt_q, idCnt_d;
    logic [2:0]      idexCnt_q, idexCnt_d;
    logic            timerClock_q, timerClock_d;
    logic [NCCM-1:0] ccifgClr_q, ccifgClr_d;

    logic selCtl, selR, selEx, selIv;
    logic wrCtl, wrR, wrEx, wrIv, rdIv, taclr;
    logic strobe, tick, advance, hwSet;
    logic [2:0] idTerm;
    logic [3:0] ivCode;

    // EQU0 is redundant with the internal TAxCCR0 compare
    logic unusedEqu0;
    assign unusedEqu0 = EQU0;

    assign selCtl = (MAB[15:1] == CTLx[15:1]);
    assign selR   = (MAB[15:1] == Rx[15:1]);
    assign selEx  = (MAB[15:1] == EXx[15:1]);
    assign selIv  = (MAB[15:1] == IVx[15:1]);
    assign wrCtl  = MW & selCtl;
    assign wrR    = MW & selR;
    assign wrEx   = MW & selEx;
    assign wrIv   = MW & selIv;
    assign rdIv   = MRD & selIv;
    assign taclr  = wrCtl & MDBwrite[2];

    // Lowest enabled channel n>=1 wins, TAIFG only when no channel pends
    always_comb begin
        ivCode = 4'h0;
        if (taifg_q && taie_q) ivCode = 4'hE;
        for (int n = NCCM - 1; n >= 1; n--) begin
            if (CCIFG[n] && CCIE[n]) ivCode = 4'(2 * n);
        end
    end

    // Control/extension register updates; a byte write leaves TASSEL alone
    always_comb begin
        tassel_d = tassel_q;
        id_d     = id_q;
        mc_d     = mc_q;
        taie_d   = taie_q;
        taidex_d = taidex_q;
        if (wrCtl) begin
            if (!BW) tassel_d = MDBwrite[9:8];
            id_d   = MDBwrite[7:6];
            mc_d   = mcMode_e'(MDBwrite[5:4]);
            taie_d = MDBwrite[1];
        end
        if (wrEx) taidex_d = MDBwrite[2:0];
    end

    // Two-stage prescaler; >= compare lets a divider shrunk mid-count
    // terminate on the next strobe instead of wrapping through 7
    always_comb begin
        unique case (tassel_q)
            2'b00:   strobe = TACLK_en;
            2'b01:   strobe = ACLK_en;
            2'b10:   strobe = SMCLK_en;
            default: strobe = INCLK_en;
        endcase
        unique case (id_q)
            2'b00:   idTerm = 3'd0;
            2'b01:   idTerm = 3'd1;
            2'b10:   idTerm = 3'd3;
            default: idTerm = 3'd7;
        endcase
        idCnt_d   = idCnt_q;
        idexCnt_d = idexCnt_q;
        tick      = 1'b0;
        if (strobe) begin
            if (idCnt_q >= idTerm) begin
                idCnt_d = 3'd0;
                if (idexCnt_q >= taidex_q) begin
                    idexCnt_d = 3'd0;
                    tick      = 1'b1;
                end else begin
                    idexCnt_d = idexCnt_q + 3'd1;
                end
            end else begin
                idCnt_d = idCnt_q + 3'd1;
            end
        end
        if (taclr) begin
            idCnt_d   = 3'd0;
            idexCnt_d = 3'd0;
        end
    end

    // Counter next state; dir_q=1 means counting down. Software loads of
    // TAxR or TACLR take the place of any tick in the same cycle.
    always_comb begin
        advance = tick && (mc_q != MC_STOP) && !taclr && !wrR;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        hwSet   = 1'b0;
        if (advance) begin
            unique case (mc_q)
                MC_UP: begin
                    if (TAxCCR0 == 16'd0) begin
                        cnt_d = 16'd0;
                    end else if (cnt_q == TAxCCR0) begin
                        cnt_d = 16'd0;
                        hwSet = 1'b1;
                    end else if (cnt_q > TAxCCR0) begin
                        cnt_d = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                MC_CONT: begin
                    cnt_d = cnt_q + 16'd1;
                    hwSet = (cnt_q == 16'hFFFF);
                end
                MC_UPDN: begin
                    if (!dir_q && (cnt_q < TAxCCR0)) begin
                        cnt_d = cnt_q + 16'd1;
                    end else if (cnt_q == 16'd0) begin
                        dir_d = 1'b0;
                        cnt_d = (TAxCCR0 != 16'd0) ? 16'd1 : 16'd0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                        dir_d = (cnt_q != 16'd1);
                        hwSet = (cnt_q == 16'd1);
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
        if (taclr) begin
            cnt_d = 16'd0;
            dir_d = 1'b0;
        end else if (wrR) begin
            cnt_d = BW ? {cnt_q[15:8], MDBwrite[7:0]} : MDBwrite;
        end
        timerClock_d = advance;
    end

    // Flag handling: later assignments win, giving hardware set the last word
    always_comb begin
        taifg_d    = taifg_q;
        ccifgClr_d = '0;
        if (rdIv && (ivCode == 4'hE)) taifg_d = 1'b0;
        for (int n = 1; n < NCCM; n++) begin
            if (rdIv && (ivCode == 4'(2 * n))) ccifgClr_d[n] = 1'b1;
        end
        if (wrCtl) taifg_d = MDBwrite[0];
        if (wrIv) begin
            taifg_d              = 1'b0;
            ccifgClr_d[NCCM-1:1] = '1;
        end
        if (hwSet) taifg_d = 1'b1;
    end

    always_comb begin
        MDBread = 16'h0000;
        if (MRD) begin
            if (selCtl)     MDBread = {6'b0, tassel_q, id_q, mc_q, 2'b00, taie_q, taifg_q};
            else if (selR)  MDBread = cnt_q;
            else if (selEx) MDBread = {13'b0, taidex_q};
            else if (selIv) MDBread = {12'b0, ivCode};
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            mc_q         <= MC_STOP;
            tassel_q     <= 2'b00;
            id_q         <= 2'b00;
            taie_q       <= 1'b0;
            taifg_q      <= 1'b0;
            taidex_q     <= 3'd0;
            cnt_q        <= 16'd0;
            dir_q        <= 1'b0;
            idCnt_q      <= 3'd0;
            idexCnt_q    <= 3'd0;
            timerClock_q <= 1'b0;
            ccifgClr_q   <= '0;
        end else begin
            mc_q         <= mc_d;
            tassel_q     <= tassel_d;
            id_q         <= id_d;
            taie_q       <= taie_d;
            taifg_q      <= taifg_d;
            taidex_q     <= taidex_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            idCnt_q      <= idCnt_d;
            idexCnt_q    <= idexCnt_d;
            timerClock_q <= timerClock_d;
            ccifgClr_q   <= ccifgClr_d;
        end
    end

    assign TAxRcurrent = cnt_q;
    assign TimerClock  = timerClock_q;
    assign CCIFGclr    = ccifgClr_q;
    assign IRQ0        = CCIFG[0] & CCIE[0];
    assign IRQ1        = (|(CCIFG[NCCM-1:1] & CCIE[NCCM-1:1])) | (taifg_q & taie_q);

endmodule

// File: tb/tb_timer_a_ctrl.sv
// tb_timer_a_ctrl
// Self-checking bench for timer_a_ctrl: table-driven count sequences for
// up and up/down modes plus hand-written sequences for the prescaler,
// interrupt vector, flag priority, TACLR and asynchronous reset cases.
module tb_timer_a_ctrl;

    localparam logic [15:0] CTLA = 16'h0340;
    localparam logic [15:0] RA   = 16'h0350;
    localparam logic [15:0] EXA  = 16'h0360;
    localparam logic [15:0] IVA  = 16'h036E;

    logic        MCLK = 1'b0;
    logic        reset;
    logic [15:0] MAB, MDBwrite;
    logic        MW, BW, MRD;
    logic        TACLK_en, ACLK_en, SMCLK_en, INCLK_en;
    logic [15:0] TAxCCR0;
    logic        EQU0;
    logic [2:0]  CCIFG, CCIE;
    logic [15:0] TAxRcurrent;
    logic        TimerClock;
    logic [2:0]  CCIFGclr;
    logic        IRQ0, IRQ1;
    logic [15:0] MDBread;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        smclk;
        logic [15:0] expR;
        logic        expTclk;
        logic [15:0] expCtl;
    } vec_t;

    vec_t vec[14];

    timer_a_ctrl #(.CTLx(CTLA), .Rx(RA), .EXx(EXA), .IVx(IVA), .NCCM(3)) dut (
        .MCLK(MCLK), .reset(reset), .MAB(MAB), .MDBwrite(MDBwrite),
        .MW(MW), .BW(BW), .MRD(MRD),
        .TACLK_en(TACLK_en), .ACLK_en(ACLK_en), .SMCLK_en(SMCLK_en), .INCLK_en(INCLK_en),
        .TAxCCR0(TAxCCR0), .EQU0(EQU0), .CCIFG(CCIFG), .CCIE(CCIE),
        .TAxRcurrent(TAxRcurrent), .TimerClock(TimerClock), .CCIFGclr(CCIFGclr),
        .IRQ0(IRQ0), .IRQ1(IRQ1), .MDBread(MDBread)
    );

    always #5 MCLK = ~MCLK;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%04h expected=0x%04h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        MAB = 16'h0; MDBwrite = 16'h0; MW = 1'b0; BW = 1'b0; MRD = 1'b0;
        TACLK_en = 1'b0; ACLK_en = 1'b0; SMCLK_en = 1'b0; INCLK_en = 1'b0;
        TAxCCR0 = 16'h0; EQU0 = 1'b0; CCIFG = 3'b0; CCIE = 3'b0;
        repeat (2) @(negedge MCLK);
        reset = 1'b1;
        @(negedge MCLK);
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data, input logic bw);
        MAB = addr; MDBwrite = data; BW = bw; MW = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        MW = 1'b0; BW = 1'b0; MAB = 16'h0; MDBwrite = 16'h0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] data);
        MAB = addr; MRD = 1'b1;
        #1 data = MDBread;
        @(posedge MCLK);
        @(negedge MCLK);
        MRD = 1'b0; MAB = 16'h0;
    endtask

    task automatic strobeCycles(input int n);
        repeat (n) begin
            SMCLK_en = 1'b1;
            @(posedge MCLK);
            @(negedge MCLK);
        end
        SMCLK_en = 1'b0;
    endtask

    // Runs vector rows lo..hi with TAxCTL held on the read bus so TAIFG is visible
    task automatic applyStimulus(input int lo, input int hi);
        MAB = CTLA; MRD = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            SMCLK_en = vec[i].smclk;
            @(posedge MCLK);
            @(negedge MCLK);
            checkOutput($sformatf("vecR[%0d]", i), TAxRcurrent, vec[i].expR);
            checkOutput($sformatf("vecTclk[%0d]", i), {15'b0, TimerClock}, {15'b0, vec[i].expTclk});
            checkOutput($sformatf("vecCtl[%0d]", i), MDBread, vec[i].expCtl);
        end
        MRD = 1'b0; MAB = 16'h0; SMCLK_en = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;

        // Up mode, CCR0=4, one idle strobe-free cycle in the middle
        vec[0]  = '{1'b1, 16'd1, 1'b1, 16'h0210};
        vec[1]  = '{1'b1, 16'd2, 1'b1, 16'h0210};
        vec[2]  = '{1'b0, 16'd2, 1'b0, 16'h0210};
        vec[3]  = '{1'b1, 16'd3, 1'b1, 16'h0210};
        vec[4]  = '{1'b1, 16'd4, 1'b1, 16'h0210};
        vec[5]  = '{1'b1, 16'd0, 1'b1, 16'h0211};
        vec[6]  = '{1'b1, 16'd1, 1'b1, 16'h0211};
        // Up/down mode, CCR0=3
        vec[7]  = '{1'b1, 16'd1, 1'b1, 16'h0230};
        vec[8]  = '{1'b1, 16'd2, 1'b1, 16'h0230};
        vec[9]  = '{1'b1, 16'd3, 1'b1, 16'h0230};
        vec[10] = '{1'b1, 16'd2, 1'b1, 16'h0230};
        vec[11] = '{1'b1, 16'd1, 1'b1, 16'h0230};
        vec[12] = '{1'b1, 16'd0, 1'b1, 16'h0231};
        vec[13] = '{1'b1, 16'd1, 1'b1, 16'h0231};

        $display("[TB] start");
        doReset();
        checkOutput("rstR", TAxRcurrent, 16'h0);
        checkOutput("rstTclk", {15'b0, TimerClock}, 16'h0);
        checkOutput("rstClr", {13'b0, CCIFGclr}, 16'h0);
        checkOutput("rstIrq", {14'b0, IRQ0, IRQ1}, 16'h0);
        checkOutput("rstMdb", MDBread, 16'h0);
        busRead(CTLA, rd); checkOutput("rstCtl", rd, 16'h0);
        busRead(EXA, rd);  checkOutput("rstEx", rd, 16'h0);

        // Up mode table
        TAxCCR0 = 16'd4;
        busWrite(CTLA, 16'h0214, 1'b0);
        checkOutput("upStartR", TAxRcurrent, 16'h0);
        applyStimulus(0, 6);

        // Up/down table
        doReset();
        TAxCCR0 = 16'd3;
        busWrite(CTLA, 16'h0234, 1'b0);
        applyStimulus(7, 13);

        // Continuous, /8 x /2 = one tick per 16 strobes, wrap sets TAIFG
        doReset();
        busWrite(EXA, 16'h0001, 1'b0);
        busWrite(CTLA, 16'h02E6, 1'b0);
        busWrite(RA, 16'hFFFE, 1'b0);
        strobeCycles(15);
        checkOutput("contR15", TAxRcurrent, 16'hFFFE);
        checkOutput("contTclk15", {15'b0, TimerClock}, 16'h0);
        strobeCycles(1);
        checkOutput("contR16", TAxRcurrent, 16'hFFFF);
        checkOutput("contTclk16", {15'b0, TimerClock}, 16'h1);
        strobeCycles(15);
        checkOutput("contIrq31", {15'b0, IRQ1}, 16'h0);
        strobeCycles(1);
        checkOutput("contR32", TAxRcurrent, 16'h0);
        checkOutput("contIrq32", {15'b0, IRQ1}, 16'h1);
        busRead(CTLA, rd); checkOutput("contCtl", rd, 16'h02E3);

        // Up mode with CCR0=0 holds at zero without TAIFG
        doReset();
        busWrite(CTLA, 16'h0216, 1'b0);
        strobeCycles(3);
        checkOutput("ccr0zR", TAxRcurrent, 16'h0);
        checkOutput("ccr0zIrq", {15'b0, IRQ1}, 16'h0);

        // Byte writes and register readback
        doReset();
        busWrite(RA, 16'h1234, 1'b0);
        busWrite(RA, 16'hFFAB, 1'b1);
        checkOutput("bwR", TAxRcurrent, 16'h12AB);
        busWrite(EXA, 16'hFFFF, 1'b0);
        busRead(EXA, rd); checkOutput("exRead", rd, 16'h0007);
        busWrite(CTLA, 16'h0200, 1'b0);
        busWrite(CTLA, 16'hFF12, 1'b1);
        busRead(CTLA, rd); checkOutput("bwCtl", rd, 16'h0212);

        // Interrupt vector arbitration and read-triggered clears
        doReset();
        busWrite(CTLA, 16'h0003, 1'b0);
        CCIFG = 3'b110; CCIE = 3'b110;
        #1 checkOutput("ivIrq1", {15'b0, IRQ1}, 16'h1);
        busRead(IVA, rd); checkOutput("iv1", rd, 16'h0002);
        checkOutput("iv1Clr", {13'b0, CCIFGclr}, 16'h0002);
        CCIFG = 3'b100;
        busRead(IVA, rd); checkOutput("iv2", rd, 16'h0004);
        checkOutput("iv2Clr", {13'b0, CCIFGclr}, 16'h0004);
        CCIFG = 3'b000;
        busRead(IVA, rd); checkOutput("iv3", rd, 16'h000E);
        checkOutput("iv3Clr", {13'b0, CCIFGclr}, 16'h0);
        busRead(CTLA, rd); checkOutput("iv3Ctl", rd, 16'h0002);
        busRead(IVA, rd); checkOutput("iv4", rd, 16'h0000);
        checkOutput("iv4Irq1", {15'b0, IRQ1}, 16'h0);
        CCIFG = 3'b001; CCIE = 3'b001;
        #1 checkOutput("irq0", {15'b0, IRQ0}, 16'h1);
        busRead(IVA, rd); checkOutput("ivCh0", rd, 16'h0000);
        CCIFG = 3'b000; CCIE = 3'b000;

        // IV write clears every channel flag and TAIFG
        busWrite(CTLA, 16'h0003, 1'b0);
        CCIFG = 3'b110;
        busWrite(IVA, 16'h0000, 1'b0);
        checkOutput("ivWrClr", {13'b0, CCIFGclr}, 16'h0006);
        CCIFG = 3'b000;
        busRead(CTLA, rd); checkOutput("ivWrCtl", rd, 16'h0002);
        checkOutput("ivWrClrEnd", {13'b0, CCIFGclr}, 16'h0);

        // Wrap coincident with the IV read that would clear TAIFG
        doReset();
        TAxCCR0 = 16'd2;
        busWrite(CTLA, 16'h0217, 1'b0);
        busWrite(RA, 16'h0002, 1'b0);
        SMCLK_en = 1'b1; MAB = IVA; MRD = 1'b1;
        #1 checkOutput("coinIv", MDBread, 16'h000E);
        @(posedge MCLK);
        @(negedge MCLK);
        MRD = 1'b0; MAB = 16'h0; SMCLK_en = 1'b0;
        checkOutput("coinR", TAxRcurrent, 16'h0);
        busRead(CTLA, rd); checkOutput("coinCtl", rd, 16'h0213);
        busRead(IVA, rd);  checkOutput("coinIv2", rd, 16'h000E);
        busRead(CTLA, rd); checkOutput("coinCtl2", rd, 16'h0212);

        // TACLR mid-count restarts the prescaler
        doReset();
        busWrite(CTLA, 16'h0264, 1'b0);
        strobeCycles(5);
        checkOutput("clrPreR", TAxRcurrent, 16'd2);
        busWrite(CTLA, 16'h0264, 1'b0);
        checkOutput("clrR", TAxRcurrent, 16'd0);
        busRead(CTLA, rd); checkOutput("clrCtl", rd, 16'h0260);
        strobeCycles(1);
        checkOutput("clrS1", TAxRcurrent, 16'd0);
        strobeCycles(1);
        checkOutput("clrS2", TAxRcurrent, 16'd1);

        // Asynchronous reset during an up/down down-count
        doReset();
        TAxCCR0 = 16'd3;
        busWrite(CTLA, 16'h0234, 1'b0);
        strobeCycles(4);
        checkOutput("arPreR", TAxRcurrent, 16'd2);
        SMCLK_en = 1'b1; MAB = IVA; MRD = 1'b1; CCIFG = 3'b010; CCIE = 3'b010;
        @(posedge MCLK);
        #2;
        checkOutput("arDownR", TAxRcurrent, 16'd1);
        checkOutput("arPendClr", {13'b0, CCIFGclr}, 16'h0002);
        reset = 1'b0;
        CCIFG = 3'b0; CCIE = 3'b0; MRD = 1'b0; MAB = 16'h0; SMCLK_en = 1'b0;
        #1;
        checkOutput("arR", TAxRcurrent, 16'h0);
        checkOutput("arTclk", {15'b0, TimerClock}, 16'h0);
        checkOutput("arClr", {13'b0, CCIFGclr}, 16'h0);
        checkOutput("arIrq", {14'b0, IRQ0, IRQ1}, 16'h0);
        @(negedge MCLK);
        reset = 1'b1;
        @(negedge MCLK);
        strobeCycles(4);
        checkOutput("arHoldR", TAxRcurrent, 16'h0);
        busRead(CTLA, rd); checkOutput("arCtl", rd, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
